// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation scheduler.
// Remaining time is held as four packed BCD digits, MM:SS.
package irrig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t dmin;
        bcd_t umin;
        bcd_t dseg;
        bcd_t useg;
    } mmss_t;

    localparam mmss_t PRESET_SHORT = 16'h1459;
    localparam mmss_t PRESET_LONG  = 16'h3959;
    localparam mmss_t LAST_SECOND  = 16'h0001;

    localparam bcd_t WRAP_NINE = 4'd9;
    localparam bcd_t WRAP_FIVE = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: synchronous load, enabled decrement with
// wrap to a programmable value, borrow out when decrementing from zero.
module bcd_down_digit import irrig_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_val,
    input  logic dec_en,
    input  bcd_t wrap_val,
    output bcd_t q,
    output logic borrow
);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (dec_en) begin
            q_d = (q_q == 4'd0) ? wrap_val : q_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment; next value comes from always_comb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign borrow = dec_en && (q_q == 4'd0);

endmodule

// File: rtl/irrigation_sched.sv
// Irrigation cycle scheduler: start/stop/pause control around a BCD MM:SS
// countdown built from four chained bcd_down_digit instances.
module irrigation_sched import irrig_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       start,
    input  logic       stop,
    input  logic       vs,
    input  logic       humid,
    input  logic       water_low,
    output logic [3:0] Dmin,
    output logic [3:0] Umin,
    output logic [3:0] Dseg,
    output logic [3:0] Useg,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [1:0] state
);

    state_e state_q, state_d;
    logic   valve_q, valve_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   aborted_q, aborted_d;
    logic   start_q;

    logic   start_rise;
    logic   abort_req;
    logic   load;
    logic   dec_en;
    mmss_t  load_val;
    mmss_t  count;
    logic   useg_borrow, dseg_borrow, umin_borrow;
    logic   unused_dmin_borrow;

    assign start_rise = start && !start_q;
    assign abort_req  = stop || humid;

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        dec_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise && !abort_req) begin
                    load     = 1'b1;
                    load_val = vs ? PRESET_LONG : PRESET_SHORT;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    load      = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (water_low) begin
                    state_d = ST_PAUSE;
                end else if (tick_1s) begin
                    dec_en = 1'b1;
                    if (count == LAST_SECOND) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort_req) begin
                    load      = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!water_low) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        valve_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // Edge register resets high so a start held through reset is not seen as a new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            valve_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            valve_q   <= valve_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            start_q   <= start;
        end
    end

    bcd_down_digit u_useg (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val.useg),
        .dec_en(dec_en), .wrap_val(WRAP_NINE), .q(count.useg), .borrow(useg_borrow)
    );
    bcd_down_digit u_dseg (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val.dseg),
        .dec_en(useg_borrow), .wrap_val(WRAP_FIVE), .q(count.dseg), .borrow(dseg_borrow)
    );
    bcd_down_digit u_umin (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val.umin),
        .dec_en(dseg_borrow), .wrap_val(WRAP_NINE), .q(count.umin), .borrow(umin_borrow)
    );
    bcd_down_digit u_dmin (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val.dmin),
        .dec_en(umin_borrow), .wrap_val(WRAP_NINE), .q(count.dmin), .borrow(unused_dmin_borrow)
    );

    assign Dmin    = count.dmin;
    assign Umin    = count.umin;
    assign Dseg    = count.dseg;
    assign Useg    = count.useg;
    assign valve   = valve_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign state   = state_q;

endmodule

// File: tb/tb_irrigation_sched.sv
// Self-checking bench: directed scenarios plus random stimulus, compared
// every cycle against a seconds-based behavioural model.
module tb_irrigation_sched;

    logic       clk = 1'b0;
    logic       reset, tick_1s, start, stop, vs, humid, water_low;
    logic [3:0] Dmin, Umin, Dseg, Useg;
    logic       valve, busy, done, aborted;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, time kept as plain seconds.
    int m_state;
    int m_secs;
    bit m_start_prev;
    bit m_done;
    bit m_aborted;
    int done_seen;
    int abort_seen;

    irrigation_sched dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s), .start(start), .stop(stop),
        .vs(vs), .humid(humid), .water_low(water_low),
        .Dmin(Dmin), .Umin(Umin), .Dseg(Dseg), .Useg(Useg),
        .valve(valve), .busy(busy), .done(done), .aborted(aborted), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int mm = secs / 60;
        int ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {Dmin, Umin, Dseg, Useg};
    endfunction

    task automatic model_reset();
        m_state      = 0;
        m_secs       = 0;
        m_start_prev = 1'b1;
        m_done       = 1'b0;
        m_aborted    = 1'b0;
    endtask

    task automatic model_clock();
        bit rise = start && !m_start_prev;
        m_start_prev = start;
        m_done       = 1'b0;
        m_aborted    = 1'b0;
        case (m_state)
            0: if (rise && !humid && !stop) begin
                   m_secs  = vs ? 39 * 60 + 59 : 14 * 60 + 59;
                   m_state = 1;
               end
            1, 2: if (stop || humid) begin
                   m_aborted = 1'b1;
                   m_secs    = 0;
                   m_state   = 0;
               end else if (m_state == 1 && water_low) begin
                   m_state = 2;
               end else if (m_state == 2) begin
                   if (!water_low) m_state = 1;
               end else if (tick_1s) begin
                   m_secs--;
                   if (m_secs == 0) begin
                       m_state = 3;
                       m_done  = 1'b1;
                   end
               end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state",   32'(state),   32'(m_state));
        check("digits",  32'(digits()), 32'(to_bcd(m_secs)));
        check("valve",   32'(valve),   32'(m_state == 1));
        check("busy",    32'(busy),    32'(m_state == 1 || m_state == 2));
        check("done",    32'(done),    32'(m_done));
        check("aborted", 32'(aborted), 32'(m_aborted));
        if (done)    done_seen++;
        if (aborted) abort_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_clock();
        #1;
        compare_all();
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_1s = 1'b1;
            step();
            tick_1s = 1'b0;
            step();
        end
    endtask

    task automatic launch(input logic sel);
        vs    = sel;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_1s = 1'b0; start = 1'b0; stop = 1'b0;
        vs = 1'b0; humid = 1'b0; water_low = 1'b0;
        done_seen = 0; abort_seen = 0;
        model_reset();
        #1;
        compare_all();
        repeat (2) step();
        reset = 1'b0;
        step();

        // Short cycle runs to completion.
        done_seen = 0;
        launch(1'b0);
        check("short_preset", 32'(digits()), 32'h1459);
        tick_n(899);
        step();
        check("short_end_digits", 32'(digits()), 32'h0000);
        check("short_end_state", 32'(state), 32'd0);
        check("short_end_valve", 32'(valve), 32'd0);
        check("short_done_pulses", 32'(done_seen), 32'd1);

        // Long cycle, vs flipped after load, borrow chain spot checks.
        done_seen = 0;
        launch(1'b1);
        vs = 1'b0;
        check("long_preset", 32'(digits()), 32'h3959);
        tick_n(1);
        check("long_3958", 32'(digits()), 32'h3958);
        tick_n(58);
        check("long_3900", 32'(digits()), 32'h3900);
        tick_n(1);
        check("long_3859", 32'(digits()), 32'h3859);
        tick_n(2338);
        check("long_0001", 32'(digits()), 32'h0001);
        check("long_no_early_done", 32'(done_seen), 32'd0);
        tick_n(1);
        check("long_done_pulses", 32'(done_seen), 32'd1);
        check("long_end_digits", 32'(digits()), 32'h0000);

        // Pause on low water at 10:00.
        launch(1'b0);
        tick_n(299);
        check("pause_at_1000", 32'(digits()), 32'h1000);
        water_low = 1'b1;
        tick_n(5);
        check("pause_state", 32'(state), 32'd2);
        check("pause_frozen", 32'(digits()), 32'h1000);
        check("pause_valve", 32'(valve), 32'd0);
        water_low = 1'b0;
        step();
        tick_n(1);
        check("resume_0959", 32'(digits()), 32'h0959);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Humid abort coinciding with a tick at 05:30.
        done_seen = 0; abort_seen = 0;
        launch(1'b0);
        tick_n(569);
        check("humid_at_0530", 32'(digits()), 32'h0530);
        humid = 1'b1; tick_1s = 1'b1;
        step();
        check("humid_aborted", 32'(aborted), 32'd1);
        check("humid_digits", 32'(digits()), 32'h0000);
        humid = 1'b0; tick_1s = 1'b0;
        step();
        check("humid_no_done", 32'(done_seen), 32'd0);
        check("humid_abort_count", 32'(abort_seen), 32'd1);

        // Asynchronous reset mid-run with start held high.
        start = 1'b1; vs = 1'b0;
        step();
        tick_n(3);
        check("pre_reset_valve", 32'(valve), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valve", 32'(valve), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_digits", 32'(digits()), 32'h0000);
        check("async_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        check("held_start_idle", 32'(state), 32'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("restart_run", 32'(state), 32'd1);
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Start refused while soil is wet.
        humid = 1'b1; start = 1'b1;
        repeat (4) begin
            step();
            check("wet_valve", 32'(valve), 32'd0);
        end
        humid = 1'b0; start = 1'b0;
        step();

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            tick_1s = ($urandom % 3) == 0;
            if (($urandom % 6) == 0)  start = ~start;
            stop  = ($urandom % 80) == 0;
            humid = ($urandom % 80) == 0;
            if (($urandom % 10) == 0) water_low = ~water_low;
            vs = 1'($urandom % 2);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
